// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM states
// and the rotating priority pick.
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of vec scanning upward from start, wrapping 7->0.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] vec,
                                    input logic [IDX_W-1:0]   start);
    pick_t            res;
    logic [IDX_W-1:0] j;
    res = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = start + IDX_W'(i);
      if (!res.found && vec[j]) begin
        res.found = 1'b1;
        res.idx   = j;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder_3_8_en.sv
// Combinational 3-to-8 one-hot decoder; all-zero output when disabled.
module decoder_3_8_en (
  input  logic       en,
  input  logic [2:0] in,
  output logic [7:0] out
);

  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with bounded hold under contention.
// Owner index, valid and hold count are registered; gnt is decoded from them.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic [NUM_REQ-1:0] others;
  pick_t              pick_idle;
  pick_t              pick_next;

  // Release and forced rotation both scan past the owner with the owner
  // masked out, so one pick serves both cases.
  always_comb begin
    others    = req & ~(NUM_REQ'(1) << gnt_idx_q);
    pick_idle = rr_pick(req, last_q + IDX_W'(1));
    pick_next = rr_pick(others, gnt_idx_q + IDX_W'(1));
  end

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_idle.found) begin
          state_d     = GRANT;
          gnt_idx_d   = pick_idle.idx;
          last_d      = pick_idle.idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (!req[gnt_idx_q] || (hold_cnt_q == HOLD_LAST)) begin
          hold_cnt_d = '0;
          if (pick_next.found) begin
            gnt_idx_d = pick_next.idx;
            last_d    = pick_next.idx;
          end else if (!req[gnt_idx_q]) begin
            state_d     = IDLE;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_idx_q   <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      last_q      <= last_d;
      gnt_valid_q <= gnt_valid_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

  decoder_3_8_en u_dec (
    .en  (gnt_valid_q),
    .in  (gnt_idx_q),
    .out (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed and randomized bench for rr_arbiter_8 against a behavioural
// owner/streak model.
module tb_rr_arbiter_8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: owner (-1 = nobody), cycles in current streak, last winner.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 7;

  rr_arbiter_8 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  function automatic int next_after(input logic [7:0] v, input int from);
    for (int k = 1; k <= 8; k++)
      if (v[(from + k) % 8]) return (from + k) % 8;
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [7:0] oth;
    int         nxt;
    if (rst) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 7;
    end else if (m_owner < 0) begin
      nxt = next_after(req, m_last);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_last  = nxt;
        m_held  = 1;
      end
    end else begin
      oth          = req;
      oth[m_owner] = 1'b0;
      nxt          = next_after(oth, m_owner);
      if (!req[m_owner] || m_held == MH) begin
        if (nxt >= 0) begin
          m_owner = nxt;
          m_last  = nxt;
          m_held  = 1;
        end else if (!req[m_owner]) begin
          m_owner = -1;
          m_held  = 0;
        end else begin
          m_held = 1;
        end
      end else begin
        m_held = m_held + 1;
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e_gnt;
    if (cmp_en) begin
      e_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
      check("model_gnt", int'(gnt), int'(e_gnt));
      check("model_idx", int'(gnt_idx), (m_owner >= 0) ? m_owner : 0);
      check("model_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
      check("onehot", int'($countones(gnt) <= 1), 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int seq [12];
    rst = 1'b1;
    req = 8'h00;
    step();
    step();
    cmp_en = 1'b1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_idx", int'(gnt_idx), 0);
    check("rst_valid", int'(gnt_valid), 0);

    // single requester
    rst = 1'b0;
    req = 8'h04;
    step();
    check("single_gnt", int'(gnt), 'h04);
    check("single_idx", int'(gnt_idx), 2);
    check("single_valid", int'(gnt_valid), 1);
    req = 8'h00;
    step();
    check("single_drop_gnt", int'(gnt), 0);
    check("single_drop_valid", int'(gnt_valid), 0);

    // round-robin alternation 0,7,0,7
    do_reset();
    req = 8'h81; step(); check("rr_0", int'(gnt_idx), 0);
    req = 8'h80; step(); check("rr_1", int'(gnt_idx), 7);
    req = 8'h01; step(); check("rr_2", int'(gnt_idx), 0);
    req = 8'h80; step(); check("rr_3", int'(gnt_idx), 7);

    // hold expiry under contention
    do_reset();
    seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    req = 8'h03;
    for (int i = 0; i < 12; i++) begin
      step();
      check("expiry_idx", int'(gnt_idx), seq[i]);
      check("expiry_valid", int'(gnt_valid), 1);
    end

    // sole owner keeps grant past expiry
    do_reset();
    req = 8'h10;
    for (int i = 0; i < 12; i++) begin
      step();
      check("sole_gnt", int'(gnt), 'h10);
    end

    // back-to-back handover 3 -> 5
    do_reset();
    req = 8'h08; step(); check("hand_3", int'(gnt_idx), 3);
    req = 8'h28; step(); check("hand_hold", int'(gnt_idx), 3);
    req = 8'h20; step(); check("hand_5", int'(gnt_idx), 5);
    check("hand_valid", int'(gnt_valid), 1);

    // wrap: owner 6 releases, only requester 0 pending
    do_reset();
    req = 8'h40; step(); check("wrap_6", int'(gnt_idx), 6);
    req = 8'h01; step(); check("wrap_0", int'(gnt_idx), 0);

    // reset mid-grant
    do_reset();
    req = 8'h04; step(); check("midrst_pre", int'(gnt_idx), 2);
    rst = 1'b1;
    req = 8'hFF;
    step();
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_valid", int'(gnt_valid), 0);
    rst = 1'b0;
    step();
    check("midrst_first", int'(gnt_idx), 0);

    // randomized traffic: mostly sticky requests, occasional rewrites and resets
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] v;
      v = req;
      if ($urandom_range(0, 19) == 0) v = 8'($urandom());
      else
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, 9) == 0) v[b] = ~v[b];
      req = v;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    // all requesting: check the fairness bound on waiting time
    begin
      int wait_c [8];
      int worst;
      do_reset();
      req   = 8'hFF;
      worst = 0;
      for (int k = 0; k < 8; k++) wait_c[k] = 0;
      for (int i = 0; i < 100; i++) begin
        step();
        for (int k = 0; k < 8; k++) begin
          if (gnt[k]) wait_c[k] = 0;
          else wait_c[k]++;
          if (wait_c[k] > worst) worst = wait_c[k];
        end
      end
      check("fair_bound", int'(worst <= 7 * MH + 1), 1);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
